dbpsk_framer_enc: RTL and testbench
===================================

DBPSK_FRAMER_ENC -- requirements
Module: dbpsk_framer_enc

Interface
REQ-001 SHALL have parameter SPS, default 8, clock cycles per symbol (>=2).
REQ-002 SHALL have parameter PRE_LEN, default 16, number of preamble symbols per frame.
REQ-003 SHALL have parameter PRE_PATTERN, default 16'hF0AC, preamble bits, sent MSB first.
REQ-004 SHALL have parameter PAY_LEN, default 127, number of payload symbols per frame (one PN period).
REQ-005 SHALL have parameter GAP_LEN, default 8, number of silent symbols after each payload.
REQ-006 SHALL have parameter AMP, default 100, output magnitude (8-bit signed).
REQ-007 clk  input  1  single clock; all logic on its rising edge.
REQ-008 reset_n  input  1  reset, asynchronous, active-low.
REQ-009 enable  input  1  level; start or continue framing.
REQ-010 din  input  1  payload bit from upstream PN source.
REQ-011 din_valid  input  1  din is valid.
REQ-012 din_ready  output  1  block takes din on this edge.
REQ-013 sym_out  output  1  current differential bit d.
REQ-014 sym_valid  output  1  high while a preamble or payload symbol is held.
REQ-015 sym_stb  output  1  one-cycle pulse in the first cycle of each new symbol.
REQ-016 iq_out  output  8  signed level: d=1 -> -AMP, d=0 -> +AMP, 0 when sym_valid=0.
REQ-017 frame_start  output  1  one-cycle pulse with the first preamble symbol.
REQ-018 underflow  output  1  one-cycle pulse when a payload bit was due and din_valid=0.

Function
REQ-019 FSM states SHALL be IDLE, PREAMBLE, PAYLOAD, GAP.
REQ-020 The symbol counter SHALL run 0..SPS-1 outside IDLE; a symbol edge is the clock edge where the count wraps from SPS-1 to 0, or the IDLE->PREAMBLE edge.
REQ-021 IDLE->PREAMBLE SHALL occur on the first edge with enable=1. On that edge: symbol counter=0, index=0, d is recomputed from d=0 (reference phase), and the first preamble bit is loaded.
REQ-022 Each symbol edge SHALL compute d_next = d_prev XOR b and register d_next, sym_stb=1, iq_out. b is the preamble bit, the payload bit, or none in GAP.
REQ-023 The index counter SHALL advance on each symbol edge. PREAMBLE->PAYLOAD after PRE_LEN symbols. PAYLOAD->GAP after PAY_LEN symbols. GAP->PREAMBLE after GAP_LEN symbols if enable=1, else GAP->IDLE.
REQ-024 din_ready SHALL be high only when the next symbol edge loads a payload bit and the symbol counter is SPS-1; the bit is consumed iff din_valid=1 on that edge.
REQ-025 On underflow, b SHALL be 0 (d holds its value) and underflow SHALL pulse on that edge; the frame SHALL continue.
REQ-026 In GAP and IDLE: sym_valid=0, iq_out=0, d holds its value, din_ready=0.
REQ-027 enable falling mid-frame SHALL NOT truncate the frame; the block SHALL exit to IDLE at the end of GAP.
REQ-028 Each symbol SHALL be held exactly SPS cycles; end-to-end latency din accept -> iq_out update SHALL be 0 cycles (same edge).

Reset
REQ-029 reset_n=0 SHALL immediately force state IDLE, counters 0, d=0, and all outputs 0, including mid-frame.
REQ-030 After reset release the block SHALL wait in IDLE until enable=1.

Structure
REQ-031 Package dbpsk_pkg SHALL hold the state enum, default PRE_PATTERN and AMP, and the counter width functions.
REQ-032 Sub-module dbpsk_sym_tick SHALL hold the SPS counter and generate the wrap tick, with sync clear and run inputs.

Verification
REQ-033 enable=1 from reset, SPS=8 -> frame_start on cycle 1; first four iq_out values -100,+100,-100,+100, each held 8 cycles.
REQ-034 Upstream always valid, din=1 for 127 bits -> 127 din_ready pulses, 8 cycles apart; d toggles every symbol; then 64 cycles of iq_out=0.
REQ-035 din_valid=0 at the 5th payload edge -> one underflow pulse; d unchanged; frame length still 16+127+8 symbols.
REQ-036 enable dropped during payload symbol 50 -> frame completes; IDLE after GAP; no second frame_start.
REQ-037 reset_n low during preamble symbol 7 -> all outputs 0 in the same cycle; with enable=1 after release, a new frame_start comes 1 cycle later and d restarts from 0.
REQ-038 Continuous enable for 3 frames -> frame_start every (16+127+8)*8=1208 cycles.

Source files
------------

// File: rtl/dbpsk_pkg.sv
// Shared types, defaults and width helpers for the DBPSK framer.
package dbpsk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_PAYLOAD,
    ST_GAP
  } state_t;

  localparam logic [15:0] DEF_PRE_PATTERN = 16'hF0AC;
  localparam int          DEF_AMP         = 100;

  // Bits needed to hold a count of 0..n-1 (never less than one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/dbpsk_sym_tick.sv
// Per-symbol cycle counter: counts 0..SPS-1 while running, flags the wrap cycle.
module dbpsk_sym_tick
  import dbpsk_pkg::*;
#(
  parameter int SPS = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int            CW   = cnt_width(SPS);
  localparam logic [CW-1:0] LAST = CW'(SPS - 1);

  logic [CW-1:0] r_cnt;

  // High in the last cycle of a symbol, so the following edge is a symbol edge.
  assign tick = run && (r_cnt == LAST);

  // Counter: synchronous clear wins over run; wraps after SPS cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (run) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dbpsk_framer_enc.sv
// DBPSK framer/encoder: preamble + payload + silent gap, differential bit d and
// an 8-bit antipodal level held for SPS cycles per symbol.
module dbpsk_framer_enc
  import dbpsk_pkg::*;
#(
  parameter int                 SPS         = 8,
  parameter int                 PRE_LEN     = 16,
  parameter logic [PRE_LEN-1:0] PRE_PATTERN = PRE_LEN'(DEF_PRE_PATTERN),
  parameter int                 PAY_LEN     = 127,
  parameter int                 GAP_LEN     = 8,
  parameter int                 AMP         = DEF_AMP
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              sym_out,
  output logic              sym_valid,
  output logic              sym_stb,
  output logic signed [7:0] iq_out,
  output logic              frame_start,
  output logic              underflow
);

  localparam int                IW       = cnt_width(max3(PRE_LEN, PAY_LEN, GAP_LEN));
  localparam logic [IW-1:0]     PRE_LAST = IW'(PRE_LEN - 1);
  localparam logic [IW-1:0]     PAY_LAST = IW'(PAY_LEN - 1);
  localparam logic [IW-1:0]     GAP_LAST = IW'(GAP_LEN - 1);
  localparam logic signed [7:0] IQ_POS   = 8'(AMP);
  localparam logic signed [7:0] IQ_NEG   = 8'(-AMP);

  state_t             r_state, w_state_next;
  logic [IW-1:0]      r_idx, w_idx_next;
  logic [PRE_LEN-1:0] r_pre_sr, w_pre_sr_next;
  logic               r_d, w_d_next;
  logic               r_valid, w_valid_next;
  logic               r_stb, w_stb_next;
  logic               r_fs, w_fs_next;
  logic               r_uf, w_uf_next;

  logic w_tick, w_clr, w_run, w_pay_due, w_pay_bit, w_start;

  // Counter is parked at 0 in IDLE so the first preamble symbol gets a full SPS cycles.
  assign w_clr = (r_state == ST_IDLE);
  assign w_run = (r_state != ST_IDLE);

  dbpsk_sym_tick #(.SPS(SPS)) u_sym_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (w_clr),
    .run     (w_run),
    .tick    (w_tick)
  );

  // The next symbol is a payload symbol: last preamble symbol, or any payload symbol but the last.
  assign w_pay_due = ((r_state == ST_PREAMBLE) && (r_idx == PRE_LAST)) ||
                     ((r_state == ST_PAYLOAD)  && (r_idx != PAY_LAST));
  assign din_ready = w_pay_due && w_tick;
  // A missing payload bit encodes as 0, leaving d unchanged.
  assign w_pay_bit = din_valid & din;

  // New frame: from IDLE immediately, or back-to-back at the end of the gap.
  assign w_start = ((r_state == ST_IDLE) && enable) ||
                   ((r_state == ST_GAP) && w_tick && (r_idx == GAP_LAST) && enable);

  assign sym_out     = r_d;
  assign sym_valid   = r_valid;
  assign sym_stb     = r_stb;
  assign frame_start = r_fs;
  assign underflow   = r_uf;
  assign iq_out      = r_valid ? (r_d ? IQ_NEG : IQ_POS) : 8'sd0;

  // Next-state and next-symbol logic; everything only moves on a symbol edge.
  always_comb begin
    w_state_next  = r_state;
    w_idx_next    = r_idx;
    w_pre_sr_next = r_pre_sr;
    w_d_next      = r_d;
    w_valid_next  = r_valid;
    w_stb_next    = 1'b0;
    w_fs_next     = 1'b0;
    w_uf_next     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
      end
      ST_PREAMBLE: begin
        if (w_tick) begin
          w_stb_next = 1'b1;
          if (r_idx == PRE_LAST) begin
            w_state_next = ST_PAYLOAD;
            w_idx_next   = '0;
            w_d_next     = r_d ^ w_pay_bit;
            w_uf_next    = ~din_valid;
          end else begin
            w_idx_next    = r_idx + 1'b1;
            w_d_next      = r_d ^ r_pre_sr[PRE_LEN-1];
            w_pre_sr_next = r_pre_sr << 1;
          end
        end
      end
      ST_PAYLOAD: begin
        if (w_tick) begin
          w_stb_next = 1'b1;
          if (r_idx == PAY_LAST) begin
            w_state_next = ST_GAP;
            w_idx_next   = '0;
            w_valid_next = 1'b0;
          end else begin
            w_idx_next = r_idx + 1'b1;
            w_d_next   = r_d ^ w_pay_bit;
            w_uf_next  = ~din_valid;
          end
        end
      end
      ST_GAP: begin
        if (w_tick) begin
          if (r_idx == GAP_LAST) begin
            w_state_next = ST_IDLE;
            w_idx_next   = '0;
          end else begin
            w_stb_next = 1'b1;
            w_idx_next = r_idx + 1'b1;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    // Frame start overrides: d restarts from the 0 reference, first pattern bit applied.
    if (w_start) begin
      w_state_next  = ST_PREAMBLE;
      w_idx_next    = '0;
      w_d_next      = PRE_PATTERN[PRE_LEN-1];
      w_pre_sr_next = PRE_PATTERN << 1;
      w_valid_next  = 1'b1;
      w_stb_next    = 1'b1;
      w_fs_next     = 1'b1;
    end
  end

  // State and output registers; reset forces IDLE with all outputs low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_pre_sr <= '0;
      r_d      <= 1'b0;
      r_valid  <= 1'b0;
      r_stb    <= 1'b0;
      r_fs     <= 1'b0;
      r_uf     <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_idx    <= w_idx_next;
      r_pre_sr <= w_pre_sr_next;
      r_d      <= w_d_next;
      r_valid  <= w_valid_next;
      r_stb    <= w_stb_next;
      r_fs     <= w_fs_next;
      r_uf     <= w_uf_next;
    end
  end

endmodule

// File: tb/tb_dbpsk_framer_enc.sv
// Scoreboard bench for dbpsk_framer_enc with default parameters.
module tb_dbpsk_framer_enc;

  localparam int SPS = 8;
  localparam int PAY = 127;
  // Differential bits over preamble F0AC starting from d=0, worked by hand:
  // b = 1111 0000 1010 1100 -> d = 1010 0000 1100 1000
  localparam logic [15:0] PRE_D = 16'hA0C8;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic enable = 1'b0;
  logic din = 1'b0;
  logic din_valid = 1'b0;
  logic din_ready, sym_out, sym_valid, sym_stb, frame_start, underflow;
  logic signed [7:0] iq_out;

  dbpsk_framer_enc dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .din         (din),
    .din_valid   (din_valid),
    .din_ready   (din_ready),
    .sym_out     (sym_out),
    .sym_valid   (sym_valid),
    .sym_stb     (sym_stb),
    .iq_out      (iq_out),
    .frame_start (frame_start),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int iq;
    int d;
    int fs;
    int uf;
    int spacing;
    int fs_period;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int n_ready = 0;
  int n_fs = 0;
  int n_uf = 0;
  int n_stray = 0;
  int n_bad_silence = 0;
  int n_sym = 0;
  int last_vstb = -1;
  int last_fs = -1;
  int last_ready = -1;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic din_of(input int f, input int k);
    case (f)
      0:       return 1'b1;
      1:       return (k % 2) == 0;
      2:       return (k % 3) == 1;
      default: return (k % 5) < 2;
    endcase
  endfunction

  function automatic int iq_of(input int d);
    return (d != 0) ? -100 : 100;
  endfunction

  // Expected symbols for one frame: preamble from the hand-worked table, payload by XOR.
  task automatic push_frame(input int f, input bit cont, input int n_pre, input bit with_pay);
    exp_t e;
    int d;
    bit v;
    logic [15:0] pd;
    pd = PRE_D;
    d = 0;
    for (int i = 0; i < n_pre; i++) begin
      d = int'(pd[15-i]);
      e.iq = iq_of(d); e.d = d; e.fs = (i == 0) ? 1 : 0; e.uf = 0;
      e.spacing   = (i == 0) ? (cont ? 72 : 0) : SPS;
      e.fs_period = (i == 0 && cont) ? 1208 : 0;
      q.push_back(e);
    end
    if (with_pay) begin
      for (int k = 0; k < PAY; k++) begin
        v = !(f == 1 && k == 4);
        if (v) d = d ^ int'(din_of(f, k));
        e.iq = iq_of(d); e.d = d; e.fs = 0; e.uf = v ? 0 : 1;
        e.spacing = SPS; e.fs_period = 0;
        q.push_back(e);
      end
    end
  endtask

  task automatic wait_ready(input int target, input int budget);
    int n = 0;
    while (n_ready < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n_ready < target) check("wait_ready_timeout", n_ready, target);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) check("drain_timeout", q.size(), 0);
  endtask

  // Upstream PN source: answers din_ready with a directed bit pattern per frame.
  initial begin : drv
    int f, k;
    forever begin
      @(negedge clk);
      if (din_ready) begin
        f = n_ready / PAY;
        k = n_ready % PAY;
        if (k > 0) check("ready_spacing", cyc - last_ready, SPS);
        last_ready = cyc;
        din = din_of(f, k);
        din_valid = !(f == 1 && k == 4);
        n_ready++;
      end else begin
        din = 1'b0;
        din_valid = 1'b1;
      end
    end
  end

  // Monitor: pops one expectation per presented symbol.
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        last_vstb = -1;
      end else begin
        if (!sym_valid && iq_out != 0) n_bad_silence++;
        if (sym_stb && sym_valid) begin
          if (frame_start) n_fs++;
          if (underflow) n_uf++;
          check("expectation_pending", int'(q.size() > 0), 1);
          if (q.size() > 0) begin
            e = q.pop_front();
            n_sym++;
            check("iq_out", int'(iq_out), e.iq);
            check("sym_out", int'(sym_out), e.d);
            check("frame_start", int'(frame_start), e.fs);
            check("underflow", int'(underflow), e.uf);
            if (e.spacing > 0) check("symbol_spacing", cyc - last_vstb, e.spacing);
            if (e.fs_period > 0) check("frame_period", cyc - last_fs, e.fs_period);
            $display("sym %0d @%0d: iq=%0d d=%0d fs=%0d uf=%0d", n_sym, cyc, iq_out, sym_out, frame_start, underflow);
          end
          last_vstb = cyc;
          if (frame_start) last_fs = cyc;
        end else if (frame_start || underflow) begin
          n_stray++;
        end
      end
    end
  end

  initial begin : stim
    int nz;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sym_out", int'(sym_out), 0);
    check("rst_sym_valid", int'(sym_valid), 0);
    check("rst_sym_stb", int'(sym_stb), 0);
    check("rst_iq_out", int'(iq_out), 0);
    check("rst_frame_start", int'(frame_start), 0);
    check("rst_underflow", int'(underflow), 0);
    check("rst_din_ready", int'(din_ready), 0);

    // Three back-to-back frames; underflow in frame 2, enable dropped in frame 3.
    push_frame(0, 1'b0, 16, 1'b1);
    push_frame(1, 1'b1, 16, 1'b1);
    push_frame(2, 1'b1, 16, 1'b1);
    enable = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("cycle1_frame_start", int'(frame_start), 1);
    check("cycle1_iq", int'(iq_out), -100);

    wait_ready(2 * PAY + 50, 5000);
    @(posedge clk);
    #1 enable = 1'b0;
    wait_drain(2500);
    repeat (8) @(negedge clk);
    nz = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (iq_out != 0 || sym_valid) nz++;
    end
    check("gap_silence_cycles", nz, 0);
    repeat (200) @(negedge clk);
    check("frames_after_drop", n_fs, 3);
    check("ready_total", n_ready, 3 * PAY);
    check("underflow_total", n_uf, 1);
    check("idle_sym_valid", int'(sym_valid), 0);

    // Start from IDLE, then reset in the middle of preamble symbol index 6.
    push_frame(3, 1'b0, 7, 1'b0);
    @(posedge clk);
    #1 enable = 1'b1;
    @(posedge clk);
    #1;
    check("restart_frame_start", int'(frame_start), 1);
    repeat (50) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_sym_valid", int'(sym_valid), 0);
    check("async_rst_iq", int'(iq_out), 0);
    check("async_rst_sym_out", int'(sym_out), 0);
    check("async_rst_din_ready", int'(din_ready), 0);
    check("partial_frame_consumed", q.size(), 0);
    q.delete();

    // Release with enable still high: frame begins on the next edge, d from 0.
    push_frame(3, 1'b0, 16, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_frame_start", int'(frame_start), 1);
    check("post_rst_sym_out", int'(sym_out), 1);
    check("post_rst_iq", int'(iq_out), -100);
    enable = 1'b0;
    wait_drain(2500);
    repeat (200) @(negedge clk);

    check("final_frame_starts", n_fs, 5);
    check("final_ready_total", n_ready, 4 * PAY);
    check("final_underflows", n_uf, 1);
    check("final_queue_empty", q.size(), 0);
    check("silent_level_violations", n_bad_silence, 0);
    check("stray_pulses", n_stray, 0);
    check("final_sym_valid", int'(sym_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
